regfile_scoreboard: RTL and testbench

//   Register file plus pending-write scoreboard at the receiving end of the writeback path.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard_pend_counter.sv | 29 ++
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing for the register file / pending-write scoreboard.
// Also holds the "still pending after this cycle's writeback" helper.
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int PEND_W   = 2;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  // A count of 1 with a writeback landing this cycle resolves to zero; 0 stays 0.
  function automatic logic pending_after_wb(input logic [PEND_W-1:0] pend, input logic hit);
    return (pend != '0) && !(hit && (pend == PEND_W'(1)));
  endfunction

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Per-register in-flight write counter. Simultaneous inc/dec cancel out.
// o_underflow flags a decrement that arrives while the count is already zero.
module pend_counter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_count,
  output logic              o_underflow
);

  logic [PEND_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_underflow = i_dec && !i_inc && (r_count == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through operand bypass and a per-register
// pending-write scoreboard that stalls decode on RAW and counter saturation.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                issue_valid,
  input  logic                issue_rd_we,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wb_underflow
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_underflow;
  logic [PEND_W-1:0]   w_pend [NUM_REGS];
  logic [NUM_REGS-1:0] w_hit;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_underflow;
  logic                w_rs1_pending;
  logic                w_rs2_pending;
  logic                w_rd_full;
  logic                w_accept;

  // r0 is hardwired: no counter, never hit, never busy.
  assign w_pend[0]      = '0;
  assign w_hit[0]       = 1'b0;
  assign w_inc[0]       = 1'b0;
  assign w_underflow[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend
      assign w_hit[gi] = wb_we && (wb_rd == ADDR_W'(gi));
      assign w_inc[gi] = w_accept && (issue_rd == ADDR_W'(gi));

      pend_counter u_pend_counter (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_inc[gi]),
        .i_dec       (w_hit[gi]),
        .o_count     (w_pend[gi]),
        .o_underflow (w_underflow[gi])
      );
    end

    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_vec[gi] = (w_pend[gi] != '0);
    end
  endgenerate

  // Sources compare against the pre-issue count, so rs==issue_rd never self-stalls.
  assign w_rs1_pending = pending_after_wb(w_pend[rs1_addr], w_hit[rs1_addr]);
  assign w_rs2_pending = pending_after_wb(w_pend[rs2_addr], w_hit[rs2_addr]);
  assign w_rd_full     = issue_rd_we && (issue_rd != '0) &&
                         (w_pend[issue_rd] == PEND_W'(PEND_MAX)) && !w_hit[issue_rd];

  assign stall    = issue_valid && (w_rs1_pending || w_rs2_pending || w_rd_full);
  assign w_accept = issue_valid && !stall && issue_rd_we && (issue_rd != '0);

  always_comb begin
    rs1_data = r_regs[rs1_addr];
    rs2_data = r_regs[rs2_addr];
    if (wb_we && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wb_we && (wb_rd == rs2_addr)) rs2_data = wb_data;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (|w_underflow) begin
      r_underflow <= 1'b1;
    end
  end

  assign wb_underflow = r_underflow;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed hazard scenarios then biased random traffic,
// all compared against an array/integer model of the scoreboard rules.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_data;
  logic                issue_valid;
  logic                issue_rd_we;
  logic [ADDR_W-1:0]   issue_rd;
  logic [ADDR_W-1:0]   rs1_addr;
  logic [ADDR_W-1:0]   rs2_addr;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;
  logic                wb_underflow;

  regfile_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .issue_valid  (issue_valid),
    .issue_rd_we  (issue_rd_we),
    .issue_rd     (issue_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .stall        (stall),
    .busy_vec     (busy_vec),
    .wb_underflow (wb_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference model: architectural values, in-flight counts, sticky error.
  int m_reg  [NUM_REGS];
  int m_pend [NUM_REGS];
  bit m_uf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_reg[r]  = 0;
      m_pend[r] = 0;
    end
    m_uf = 1'b0;
  endfunction

  // One cycle: drive, check combinational/registered outputs, advance model, clock.
  task automatic step(input bit we, input int rd, input int data, input bit iv,
                      input bit iwe, input int ird, input int a1, input int a2);
    int  hit [NUM_REGS];
    int  e1, e2, x1, x2;
    bit  full, x_stall, acc;
    logic [NUM_REGS-1:0] x_busy;
    wb_we = we; wb_rd = ADDR_W'(rd); wb_data = DATA_W'(data);
    issue_valid = iv; issue_rd_we = iwe; issue_rd = ADDR_W'(ird);
    rs1_addr = ADDR_W'(a1); rs2_addr = ADDR_W'(a2);
    #4;
    for (int r = 0; r < NUM_REGS; r++) hit[r] = (we && rd == r && r != 0) ? 1 : 0;
    x1 = (a1 == 0) ? 0 : (we && rd == a1) ? data : m_reg[a1];
    x2 = (a2 == 0) ? 0 : (we && rd == a2) ? data : m_reg[a2];
    e1 = m_pend[a1] - hit[a1]; if (e1 < 0) e1 = 0;
    e2 = m_pend[a2] - hit[a2]; if (e2 < 0) e2 = 0;
    full    = iwe && ird != 0 && m_pend[ird] == PEND_MAX && hit[ird] == 0;
    x_stall = iv && (e1 != 0 || e2 != 0 || full);
    for (int r = 0; r < NUM_REGS; r++) x_busy[r] = (m_pend[r] != 0);
    check("rs1_data", 32'(rs1_data), 32'(x1));
    check("rs2_data", 32'(rs2_data), 32'(x2));
    check("stall", 32'(stall), 32'(x_stall));
    check("busy_vec", 32'(busy_vec), 32'(x_busy));
    check("wb_underflow", 32'(wb_underflow), 32'(m_uf));
    $display("txn %0d: wb=%0b r%0d %02h iss=%0b/%0b r%0d rs=r%0d,r%0d -> rs1=%02h rs2=%02h stall=%0b busy=%08b uf=%0b",
             n_txn, we, rd, data, iv, iwe, ird, a1, a2, rs1_data, rs2_data, stall, busy_vec, wb_underflow);
    n_txn++;
    acc = iv && !x_stall && iwe && ird != 0;
    for (int r = 1; r < NUM_REGS; r++) begin
      bit inc;
      inc = acc && ird == r;
      if (inc && hit[r] == 0) m_pend[r]++;
      else if (!inc && hit[r] != 0) begin
        if (m_pend[r] > 0) m_pend[r]--;
        else m_uf = 1'b1;
      end
    end
    if (we && rd != 0) m_reg[rd] = data & 8'hFF;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_we = 0; wb_rd = '0; wb_data = '0;
    issue_valid = 0; issue_rd_we = 0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset, then a dropped write to r0.
    step(0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 0, 8'hFF, 0, 0, 0, 0, 0);
    check("r0_busy", 32'(busy_vec[0]), 32'd0);
    check("r0_no_underflow", 32'(wb_underflow), 32'd0);

    // Same-cycle bypass then stored value.
    step(0, 0, 0, 1, 1, 2, 0, 0);
    step(1, 2, 8'hA5, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 2, 0);
    check("r2_stored", 32'(rs1_data), 32'hA5);

    // RAW stall until the writeback arrives.
    step(0, 0, 0, 1, 1, 4, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 4);
    step(1, 4, 8'h3C, 1, 0, 0, 0, 4);

    // Saturate r5, then issue alongside a writeback to r5.
    repeat (3) step(0, 0, 0, 1, 1, 5, 0, 0);
    step(0, 0, 0, 1, 1, 5, 0, 0);
    step(1, 5, 8'h21, 1, 1, 5, 0, 0);
    check("r5_still_busy", 32'(busy_vec[5]), 32'd1);
    repeat (3) step(1, 5, 8'h22, 0, 0, 0, 0, 0);
    check("r5_drained", 32'(busy_vec[5]), 32'd0);
    check("no_underflow_yet", 32'(wb_underflow), 32'd0);

    // Writeback to an idle register: data lands, error sticks.
    step(1, 6, 8'h11, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 6, 0);
    check("underflow_set", 32'(wb_underflow), 32'd1);
    check("r6_data", 32'(rs1_data), 32'h11);

    // Mid-run asynchronous reset with r3 pending=2, r3=0x5A.
    repeat (3) step(0, 0, 0, 1, 1, 3, 0, 0);
    step(1, 3, 8'h5A, 0, 0, 0, 0, 0);
    wb_we = 0; issue_valid = 1; issue_rd_we = 0; rs1_addr = 3'd3; rs2_addr = 3'd3;
    #2;
    check("pre_reset_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_busy", 32'(busy_vec), 32'd0);
    check("reset_rs1", 32'(rs1_data), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_uf", 32'(wb_underflow), 32'd0);
    wb_we = 1; wb_rd = 3'd3; wb_data = 8'h77; issue_rd_we = 1; issue_rd = 3'd3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(0, 0, 0, 1, 0, 0, 3, 0);

    // Biased random traffic: writebacks usually target a busy register.
    for (int i = 0; i < 400; i++) begin
      int rd, ird;
      rd = $urandom_range(0, NUM_REGS - 1);
      if ($urandom_range(0, 3) != 0) begin
        for (int t = 0; t < 8; t++) begin
          int c;
          c = $urandom_range(1, NUM_REGS - 1);
          if (m_pend[c] > 0) begin
            rd = c;
            break;
          end
        end
      end
      ird = $urandom_range(0, NUM_REGS - 1);
      step($urandom_range(0, 1), rd, $urandom_range(0, 255), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, ird, $urandom_range(0, NUM_REGS - 1),
           $urandom_range(0, NUM_REGS - 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
